uart_fifo_tx: RTL and testbench
===============================

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001: Parameter DATA_WIDTH, default 8, is the serial data word width in bits.
REQ-002: i_clk  input  1  is the single clock; all state is updated on its rising edge.
REQ-003: i_rstn  input  1  is the reset, synchronous and active-low.
REQ-004: i_fifo_empty  input  1  is the async FIFO read-side empty flag.
REQ-005: i_fifo_data  input  DATA_WIDTH  is the FIFO read data, combinational from the read pointer and valid while i_fifo_empty=0; integration connects the low DATA_WIDTH bits of the FIFO word.
REQ-006: o_fifo_rd_inc  output  1  is a one-cycle pop strobe to the FIFO read increment.
REQ-007: i_div  input  16  is the bit period in i_clk cycles; 0 is treated as 1.
REQ-008: i_par_en  input  1  enables the parity bit (1=on).
REQ-009: i_par_typ  input  1  selects parity type (0=even, 1=odd).
REQ-010: o_tx  output  1  is the serial line output, idle high.
REQ-011: o_busy  output  1  is high whenever a frame is in progress.

Function
REQ-012: FSM states SHALL be IDLE, START, DATA, PARITY, STOP; o_busy=1 in every state except IDLE.
REQ-013: In IDLE with i_fifo_empty=0, o_fifo_rd_inc SHALL be 1 for that cycle only, and on the same edge i_fifo_data, i_div, i_par_en and i_par_typ are latched and the state moves to START.
REQ-014: o_fifo_rd_inc SHALL never be high outside IDLE, and SHALL never be high in two cycles less than 3 cycles apart, to tolerate the FIFO empty-flag update latency.
REQ-015: o_tx SHALL be registered; it drives 0 starting the cycle after the pop edge.
REQ-016: Each bit (start, data, parity, stop) SHALL last exactly max(latched div,1) cycles, timed by a 16-bit down counter.
REQ-017: Data bits SHALL be sent LSB first from a shift register; a bit counter counts DATA_WIDTH bits before leaving DATA.
REQ-018: After DATA, the state moves to PARITY if par_en=1, otherwise to STOP.
REQ-019: The parity bit SHALL be XOR of the latched data for even parity and its inverse for odd parity.
REQ-020: STOP drives o_tx=1 for one bit period, then the state moves to IDLE.
REQ-021: IDLE SHALL last at least one cycle between frames, with o_tx=1, giving a 1-cycle gap between back-to-back frames.
REQ-022: Changes to i_div, i_par_en or i_par_typ mid-frame SHALL NOT affect the frame in progress.
REQ-023: Changes to i_fifo_data while not in IDLE SHALL be ignored.
REQ-024: A frame is DATA_WIDTH+2 bit periods, or DATA_WIDTH+3 with parity; busy time per frame is that count multiplied by div.

Reset
REQ-025: While i_rstn=0 at a rising edge, the block SHALL enter IDLE with o_tx=1, o_busy=0 and o_fifo_rd_inc=0, and SHALL clear the shift register, bit counter and cycle counter.
REQ-026: Reset asserted mid-frame SHALL abort the frame, with o_tx=1 from the next cycle; the popped word is discarded and not re-popped.
REQ-027: No pop SHALL occur in any cycle in which i_rstn=0.

Verification
REQ-028: Reset, then i_fifo_empty=1 for 50 cycles -> o_tx=1, o_busy=0, o_fifo_rd_inc never asserted.
REQ-029: div=4, par_en=0, data 0xA5 -> one rd_inc pulse; o_tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; o_busy high for 40 cycles.
REQ-030: div=2, par_en=1 with data 0x07 -> parity bit 1 for even and 0 for odd; frame is 11 bits (22 cycles).
REQ-031: 0x55 and 0x0F queued, div=1, no parity -> rd_inc pulses exactly 11 cycles apart; frames separated by exactly one idle-high cycle; bit sequence matches LSB-first order.
REQ-032: i_rstn low for one edge during data bit 3 -> next cycle o_tx=1 and o_busy=0; after release with i_fifo_empty=1, the line stays idle and no rd_inc.
REQ-033: div=0, data 0xFF -> identical timing to div=1 (10 cycles busy); changing i_div to 8 mid-frame leaves the current frame timing unchanged.

Source files
------------

// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops words from an async FIFO read port and sends them as
// start / DATA_WIDTH data (LSB first) / optional parity / stop frames.
module uart_fifo_tx #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_fifo_empty,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   output logic                  o_fifo_rd_inc,
   input  logic [15:0]           i_div,
   input  logic                  i_par_en,
   input  logic                  i_par_typ,
   output logic                  o_tx,
   output logic                  o_busy
);

   localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [15:0]           cyc_cnt_q, cyc_cnt_d;
   logic [15:0]           div_q, div_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic                  tx_q, tx_d;
   logic                  pop;
   logic                  bit_done;
   logic [15:0]           div_eff;

   // State register; synchronous reset aborts any frame and forces the line idle
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         cyc_cnt_q <= '0;
         div_q     <= 16'd1;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         cyc_cnt_q <= cyc_cnt_d;
         div_q     <= div_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         tx_q      <= tx_d;
      end
   end

   // Next-state logic; tx_d is the line level for the state being entered, so o_tx is
   // a pure register output
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      div_d     = div_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      tx_d      = tx_q;
      pop       = 1'b0;
      div_eff   = (i_div == 16'd0) ? 16'd1 : i_div;
      bit_done  = (cyc_cnt_q == 16'd0);
      // div_q is always >= 1, so the reload never underflows
      cyc_cnt_d = bit_done ? (div_q - 16'd1) : (cyc_cnt_q - 16'd1);

      unique case (state_q)
         StIdle: begin
            tx_d      = 1'b1;
            cyc_cnt_d = cyc_cnt_q;
            if (!i_fifo_empty) begin
               pop       = 1'b1;
               state_d   = StStart;
               shift_d   = i_fifo_data;
               div_d     = div_eff;
               par_en_d  = i_par_en;
               par_bit_d = (^i_fifo_data) ^ i_par_typ;
               cyc_cnt_d = div_eff - 16'd1;
               tx_d      = 1'b0;
            end
         end
         StStart: begin
            if (bit_done) begin
               state_d   = StData;
               bit_cnt_d = '0;
               tx_d      = shift_q[0];
            end
         end
         StData: begin
            if (bit_done) begin
               if (bit_cnt_q == LastBit) begin
                  state_d = par_en_q ? StParity : StStop;
                  tx_d    = par_en_q ? par_bit_q : 1'b1;
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  tx_d      = shift_d[0];
               end
            end
         end
         StParity: begin
            if (bit_done) begin
               state_d = StStop;
               tx_d    = 1'b1;
            end
         end
         StStop: begin
            if (bit_done) begin
               state_d = StIdle;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase
   end

   // Outputs; a frame is at least two bit periods plus the idle cycle, so pops are
   // always at least 3 cycles apart
   always_comb begin
      o_fifo_rd_inc = pop & i_rstn;
      o_busy        = (state_q != StIdle);
      o_tx          = tx_q;
   end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Self-checking bench for uart_fifo_tx: per-cycle scoreboard against a frame-level model,
// a table of single-frame vectors, directed corner sequences and randomized traffic.
module tb_uart_fifo_tx;

   typedef struct {
      logic [7:0]  data;
      logic [15:0] div;
      logic        par_en;
      logic        par_typ;
      int          busy;
      logic        pbit;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        fifo_empty;
   logic [7:0]  fifo_data;
   logic        rd_inc;
   logic [15:0] div = 16'd1;
   logic        par_en = 1'b0;
   logic        par_typ = 1'b0;
   logic        tx;
   logic        busy;

   logic [7:0]  fifo_q[$];
   logic        expq[$];
   logic        txlog[$];
   int          pulse_t[$];

   int  n_chk = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  pulses = 0;
   int  busy_cnt = 0;
   bit  chk_en = 0;
   bit  pop_pend = 0;
   logic exp_tx, exp_busy, exp_rd;
   int  d_m;
   logic [7:0] w_m;
   vec_t vecs[7];

   uart_fifo_tx #(.DATA_WIDTH(8)) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_fifo_empty (fifo_empty),
      .i_fifo_data  (fifo_data),
      .o_fifo_rd_inc(rd_inc),
      .i_div        (div),
      .i_par_en     (par_en),
      .i_par_typ    (par_typ),
      .o_tx         (tx),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic void refresh();
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = fifo_empty ? 8'($urandom) : fifo_q[0];
   endfunction

   function automatic void add_bit(input logic b, input int d);
      for (int i = 0; i < d; i++) expq.push_back(b);
   endfunction

   function automatic logic log_bit(input int idx);
      return (idx < txlog.size()) ? txlog[idx] : 1'bx;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [7:0] w);
      fifo_q.push_back(w);
      refresh();
   endtask

   task automatic wait_idle(input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         step();
         if (fifo_empty && !busy && !pop_pend) done = 1;
      end
      if (!done) chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   // Frame-level model: each pop appends the whole expected line waveform for that word
   always @(negedge clk) begin
      cyc++;
      exp_tx   = (expq.size() != 0) ? expq[0] : 1'b1;
      exp_busy = (expq.size() != 0);
      exp_rd   = (expq.size() == 0) && (fifo_q.size() != 0) && rstn;
      if (chk_en) begin
         chk("tx", {31'd0, tx}, {31'd0, exp_tx});
         chk("busy", {31'd0, busy}, {31'd0, exp_busy});
         chk("rd_inc", {31'd0, rd_inc}, {31'd0, exp_rd});
      end
      if (expq.size() != 0) void'(expq.pop_front());
      if (!rstn) expq.delete();
      if (busy === 1'b1) begin
         busy_cnt++;
         txlog.push_back(tx);
      end
      if (rd_inc === 1'b1) begin
         pulses++;
         pulse_t.push_back(cyc);
      end
      if (exp_rd) begin
         w_m = fifo_q[0];
         d_m = (div == 16'd0) ? 1 : int'(div);
         add_bit(1'b0, d_m);
         for (int k = 0; k < 8; k++) add_bit(w_m[k], d_m);
         if (par_en) add_bit((^w_m) ^ par_typ, d_m);
         add_bit(1'b1, d_m);
         pop_pend = 1;
      end
   end

   always @(posedge clk) begin
      #1;
      if (pop_pend) begin
         void'(fifo_q.pop_front());
         pop_pend = 0;
         refresh();
      end
   end

   task automatic run_vec(input vec_t v);
      int d;
      int p0;
      logic [7:0] got;
      step();
      div = v.div;
      par_en = v.par_en;
      par_typ = v.par_typ;
      txlog.delete();
      busy_cnt = 0;
      p0 = pulses;
      push(v.data);
      wait_idle(400);
      d = (v.div == 16'd0) ? 1 : int'(v.div);
      chk("vec_busy_cycles", busy_cnt, v.busy);
      chk("vec_pop_count", pulses - p0, 1);
      chk("vec_start_bit", {31'd0, log_bit(d / 2)}, 32'd0);
      for (int k = 0; k < 8; k++) got[k] = log_bit(d * (1 + k) + d / 2);
      chk("vec_data", {24'd0, got}, {24'd0, v.data});
      if (v.par_en) chk("vec_parity", {31'd0, log_bit(d * 9 + d / 2)}, {31'd0, v.pbit});
   endtask

   initial begin
      int p0;
      logic [7:0] got;
      vecs[0] = '{8'hA5, 16'd4, 1'b0, 1'b0, 40, 1'b0};
      vecs[1] = '{8'h07, 16'd2, 1'b1, 1'b0, 22, 1'b1};
      vecs[2] = '{8'h07, 16'd2, 1'b1, 1'b1, 22, 1'b0};
      vecs[3] = '{8'hFF, 16'd0, 1'b0, 1'b0, 10, 1'b0};
      vecs[4] = '{8'hFF, 16'd1, 1'b0, 1'b0, 10, 1'b0};
      vecs[5] = '{8'h00, 16'd3, 1'b1, 1'b0, 33, 1'b0};
      vecs[6] = '{8'h80, 16'd1, 1'b1, 1'b1, 11, 1'b0};
      refresh();

      // Reset, then idle with an empty FIFO
      repeat (3) step();
      chk_en = 1;
      rstn = 1;
      p0 = pulses;
      repeat (50) step();
      chk("idle_no_pop", pulses - p0, 0);
      chk("idle_tx", {31'd0, tx}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // No pop while reset is held, even with data waiting
      rstn = 0;
      push(8'h3C);
      p0 = pulses;
      repeat (3) step();
      chk("no_pop_in_reset", pulses - p0, 0);
      div = 16'd1;
      rstn = 1;
      busy_cnt = 0;
      wait_idle(100);
      chk("post_reset_frame", busy_cnt, 10);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Back-to-back frames at div=1
      step();
      div = 16'd1;
      par_en = 0;
      txlog.delete();
      pulse_t.delete();
      push(8'h55);
      push(8'h0F);
      wait_idle(100);
      chk("b2b_pop_count", pulse_t.size(), 2);
      if (pulse_t.size() == 2) chk("b2b_pop_spacing", pulse_t[1] - pulse_t[0], 11);
      for (int k = 0; k < 8; k++) got[k] = log_bit(11 + k);
      chk("b2b_second_data", {24'd0, got}, 32'h0F);

      // Reset pulse during data bit 3
      step();
      div = 16'd2;
      push(8'hA5);
      step();
      chk("rst_frame_started", {31'd0, busy}, 32'd1);
      repeat (8) step();
      rstn = 0;
      step();
      rstn = 1;
      chk("rst_abort_tx", {31'd0, tx}, 32'd1);
      chk("rst_abort_busy", {31'd0, busy}, 32'd0);
      p0 = pulses;
      repeat (20) step();
      chk("rst_no_repop", pulses - p0, 0);
      chk("rst_idle_tx", {31'd0, tx}, 32'd1);

      // div=0 frame with i_div changed mid-frame
      step();
      div = 16'd0;
      par_en = 0;
      busy_cnt = 0;
      push(8'hFF);
      step();
      div = 16'd8;
      wait_idle(100);
      chk("div0_midchange_busy", busy_cnt, 10);

      // Randomized traffic with mid-frame config and FIFO-data churn
      for (int it = 0; it < 40; it++) begin
         step();
         div = 16'($urandom_range(0, 4));
         par_en = 1'($urandom);
         par_typ = 1'($urandom);
         for (int n = 0; n < int'($urandom_range(1, 3)); n++) push(8'($urandom));
         repeat ($urandom_range(0, 15)) step();
         div = 16'($urandom_range(0, 6));
         par_en = 1'($urandom);
         par_typ = 1'($urandom);
         if ($urandom_range(0, 1) == 1) push(8'($urandom));
         wait_idle(800);
      end

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
